csr_access_ctrl: RTL and testbench
==================================

// Module: csr_access_ctrl
// PURPOSE
//  Initiator side of the CSR file interface. Sits in the execute stage and turns one Zicsr
//  instruction (CSRRW/S/C and the immediate forms) into read and/or write accesses on the CSR
//  file's operation/addr/data_wr/data_out/done/error port. Applies Zicsr side-effect suppression,
//  read-only address checks and an access timeout, then returns old value + illegal flag to core.
// PARAMETERS
//  MXLEN    32  CSR data width
//  TIMEOUT  16  max cycles waiting for csr_done per access; 0 = wait forever
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      async active-low reset
//  req_valid     in   1      core presents a CSR instruction
//  req_ready     out  1      controller idle, request accepted when valid&ready
//  req_funct3    in   3      instr[14:12]
//  req_csr_addr  in   12     instr[31:20]
//  req_rs1_field in   5      instr[19:15] (rs1 index, or uimm for immediate forms)
//  req_rs1_val   in   MXLEN  rs1 register value
//  req_rd_zero   in   1      rd == x0
//  rsp_valid     out  1      one-cycle response strobe
//  rsp_rdata     out  MXLEN  old CSR value (for rd writeback)
//  rsp_illegal   out  1      illegal-instruction exception for this request
//  instret_inc   out  1      pulse with rsp_valid when !rsp_illegal
//  csr_req       out  1      access strobe, held until csr_done, error or timeout
//  csr_operation out  1      1 = write, 0 = read
//  csr_addr      out  12     CSR address, stable while csr_req
//  csr_data_wr   out  MXLEN  write data, stable while csr_req
//  csr_data_out  in   MXLEN  read data, valid with csr_done
//  csr_done      in   1      access complete, sampled at posedge while csr_req=1
//  csr_error     in   1      access rejected, qualified by csr_done
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
//  Decode at accept:
//   operand = funct3[2] ? zext(rs1_field) : rs1_val
//   do_read = !(RW-form && rd_zero)
//   do_write = RW-form || rs1_field != 0
//   illegal_dec = funct3 in {000,100} || (csr_addr[11:10]==2'b11 && do_write)
//  FSM:
//   IDLE: req_ready=1. On req_valid, latch fields. illegal_dec -> RESP(illegal).
//         do_read -> RD. Otherwise -> WR.
//   RD: csr_req=1, operation=0. On done&error -> RESP(illegal).
//       On done: old = csr_data_out; new = RW ? operand : S ? old|operand : old&~operand.
//       Then -> WR if do_write, else RESP.
//   WR: csr_req=1, operation=1, data_wr=new. On done -> RESP, illegal=csr_error.
//   RESP: rsp_valid=1 for exactly 1 cycle; rsp_rdata=old (0 if no read); -> IDLE.
//  req_ready=0 outside IDLE; no back-pressure on rsp.
//  Minimum latency accept->rsp_valid: 1 cycle (illegal decode); 2 (one access, done in 1st cycle);
//   3 (read+write).
//  Timeout: counter clears on entering RD/WR and increments each cycle without done. When it
//   reaches TIMEOUT-1 without done: csr_req drops next cycle, -> RESP(illegal); a late done is ignored.
//  csr_req drops in the cycle after done; back-to-back RD->WR is never merged.
//  Reset mid-access: csr_req and all outputs clear asynchronously; no response is produced.
// STRUCTURE
//  csr_pkg: funct3 enum (CSRRW=001 … CSRRCI=111); CSR address constants (MTVEC 305, MEPC 341,
//   MCAUSE 342, CYCLE B00/B80, TIME C01/C81, INSTRET B02/B82); FSM state enum.
//  Sub-module csr_rmw_alu (combinational): funct3, old, operand -> new value.
// TESTING
//  1. CSRRW 0x341, rs1=0x45456767, old=0 -> RD then WR with data_wr=0x45456767; rdata=0, illegal=0,
//     instret_inc=1.
//  2. CSRRS 0x342, rs1_val=0x4, old=0x32324141 -> write 0x32324145, rdata=0x32324141.
//     CSRRCI uimm=1 -> write 0x32324144.
//  3. CSRRS 0xB00, rs1_field=0 -> single read, no WR. CSRRW rd=x0 -> WR only, rdata=0.
//  4. CSRRW 0xC01 (read-only) -> no csr_req, rsp_illegal=1 one cycle after accept;
//     funct3=100 -> same. CSRRS 0xC01, rs1=x0 -> legal.
//  5. Write 0x305 with csr_error=1 -> rsp_illegal=1, instret_inc=0.
//     csr_done held low -> rsp_illegal after TIMEOUT=16 cycles.
//  6. rst_n low during WR -> csr_req=0 immediately, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access path.
// Funct3 encodings, well-known CSR addresses, FSM states.
package csr_pkg;

  typedef enum logic [2:0] {
    F3_NONE = 3'b000,
    CSRRW   = 3'b001,
    CSRRS   = 3'b010,
    CSRRC   = 3'b011,
    F3_RSV  = 3'b100,
    CSRRWI  = 3'b101,
    CSRRSI  = 3'b110,
    CSRRCI  = 3'b111
  } csr_funct3_e;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } csr_state_e;

  // Address space 0xC00-0xFFF is read-only
  function automatic logic csr_is_ro(
    input logic [11:0] addr
  );
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write value for CSRRW/S/C and immediate forms.
// Pure combinational: old value and operand in, new value out.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int MXLEN = 32
) (
  input  csr_funct3_e      i_funct3,
  input  logic [MXLEN-1:0] i_old,
  input  logic [MXLEN-1:0] i_operand,
  output logic [MXLEN-1:0] o_new
);

  logic w_is_w;
  logic w_is_s;
  logic w_is_c;

  assign w_is_w = i_funct3 inside {CSRRW, CSRRWI};
  assign w_is_s = i_funct3 inside {CSRRS, CSRRSI};
  assign w_is_c = i_funct3 inside {CSRRC, CSRRCI};

  // Select write, set or clear of the old value
  always_comb begin
    o_new = i_old;
    unique case (1'b1)
      w_is_w:  o_new = i_operand;
      w_is_s:  o_new = i_old | i_operand;
      w_is_c:  o_new = i_old & ~i_operand;
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Execute-stage initiator for the CSR file port.
// One Zicsr instruction -> read and/or write access + response.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int MXLEN   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [11:0]      req_csr_addr,
  input  logic [4:0]       req_rs1_field,
  input  logic [MXLEN-1:0] req_rs1_val,
  input  logic             req_rd_zero,
  output logic             rsp_valid,
  output logic [MXLEN-1:0] rsp_rdata,
  output logic             rsp_illegal,
  output logic             instret_inc,
  output logic             csr_req,
  output logic             csr_operation,
  output logic [11:0]      csr_addr,
  output logic [MXLEN-1:0] csr_data_wr,
  input  logic [MXLEN-1:0] csr_data_out,
  input  logic             csr_done,
  input  logic             csr_error
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  csr_state_e       r_state;
  csr_state_e       w_state_n;
  csr_funct3_e      r_funct3;
  logic [11:0]      r_addr;
  logic [MXLEN-1:0] r_operand;
  logic             r_do_write;
  logic [MXLEN-1:0] r_old;
  logic [MXLEN-1:0] r_new;
  logic             r_illegal;
  logic [CW-1:0]    r_cnt;

  logic             w_rw;
  logic [MXLEN-1:0] w_operand;
  logic             w_do_read;
  logic             w_do_write;
  logic             w_ill_dec;
  logic             w_accept;
  logic             w_tmo;
  logic             w_ld_old;
  logic             w_set_ill;
  logic [MXLEN-1:0] w_alu_new;

  // Instruction decode on the incoming request
  always_comb begin
    w_rw       = req_funct3[1:0] == 2'b01;
    w_operand  = req_funct3[2] ? MXLEN'(req_rs1_field)
                               : req_rs1_val;
    w_do_read  = !(w_rw && req_rd_zero);
    w_do_write = w_rw || (req_rs1_field != 5'd0);
    w_ill_dec  = (req_funct3[1:0] == 2'b00) ||
                 (csr_is_ro(req_csr_addr) && w_do_write);
  end

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Last allowed waiting cycle without done; 0 disables
  assign w_tmo = (TIMEOUT != 0) && !csr_done &&
                 (r_cnt == CW'(TIMEOUT - 1));

  csr_rmw_alu #(
    .MXLEN(MXLEN)
  ) u_alu (
    .i_funct3 (r_funct3),
    .i_old    (csr_data_out),
    .i_operand(r_operand),
    .o_new    (w_alu_new)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_n     = r_state;
    w_ld_old      = 1'b0;
    w_set_ill     = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    csr_req       = 1'b0;
    csr_operation = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_ill_dec)      w_state_n = S_RESP;
          else if (w_do_read) w_state_n = S_RD;
          else                w_state_n = S_WR;
        end
      end
      S_RD: begin
        csr_req = 1'b1;
        if (csr_done) begin
          if (csr_error) begin
            w_set_ill = 1'b1;
            w_state_n = S_RESP;
          end else begin
            w_ld_old  = 1'b1;
            w_state_n = r_do_write ? S_WR : S_RESP;
          end
        end else if (w_tmo) begin
          w_set_ill = 1'b1;
          w_state_n = S_RESP;
        end
      end
      S_WR: begin
        csr_req       = 1'b1;
        csr_operation = 1'b1;
        if (csr_done) begin
          w_set_ill = csr_error;
          w_state_n = S_RESP;
        end else if (w_tmo) begin
          w_set_ill = 1'b1;
          w_state_n = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Latched request fields, old/new values and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3   <= F3_NONE;
      r_addr     <= '0;
      r_operand  <= '0;
      r_do_write <= 1'b0;
      r_old      <= '0;
      r_new      <= '0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_funct3   <= csr_funct3_e'(req_funct3);
        r_addr     <= req_csr_addr;
        r_operand  <= w_operand;
        r_do_write <= w_do_write;
        r_old      <= '0;
        r_new      <= w_operand;
        r_illegal  <= w_ill_dec;
      end
      if (w_ld_old) begin
        r_old <= csr_data_out;
        r_new <= w_alu_new;
      end
      if (w_set_ill) r_illegal <= 1'b1;
      if (r_state != w_state_n)
        r_cnt <= '0;
      else if (csr_req && !csr_done)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign csr_addr    = r_addr;
  assign csr_data_wr = r_new;
  assign rsp_rdata   = rsp_valid ? r_old : '0;
  assign rsp_illegal = rsp_valid && r_illegal;
  assign instret_inc = rsp_valid && !r_illegal;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed scenarios plus random
// instructions against a CSR-file model and Zicsr reference.
module tb_csr_access_ctrl;

  localparam int MXLEN = 32;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [11:0]      req_csr_addr;
  logic [4:0]       req_rs1_field;
  logic [MXLEN-1:0] req_rs1_val;
  logic             req_rd_zero;
  logic             rsp_valid;
  logic [MXLEN-1:0] rsp_rdata;
  logic             rsp_illegal;
  logic             instret_inc;
  logic             csr_req;
  logic             csr_operation;
  logic [11:0]      csr_addr;
  logic [MXLEN-1:0] csr_data_wr;
  logic [MXLEN-1:0] csr_data_out;
  logic             csr_done;
  logic             csr_error;

  always #5 clk = ~clk;

  csr_access_ctrl #(.MXLEN(MXLEN), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_field(req_rs1_field),
    .req_rs1_val  (req_rs1_val),
    .req_rd_zero  (req_rd_zero),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_illegal  (rsp_illegal),
    .instret_inc  (instret_inc),
    .csr_req      (csr_req),
    .csr_operation(csr_operation),
    .csr_addr     (csr_addr),
    .csr_data_wr  (csr_data_wr),
    .csr_data_out (csr_data_out),
    .csr_done     (csr_done),
    .csr_error    (csr_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [logic [11:0]];

  typedef struct {
    int          n_rd;
    int          n_wr;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        ill;
    logic        inst;
    int          lat;
    logic        got;
    logic        one;
  } res_t;

  function automatic logic [31:0] mem_rd(input logic [11:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic int acc_cycles(input int d);
    return (d < TO) ? d + 1 : TO;
  endfunction

  // Reference: Zicsr rules applied to the CSR file contents
  task automatic model(
    input  logic [2:0]  f3,
    input  logic [11:0] a,
    input  logic [4:0]  fld,
    input  logic [31:0] v,
    input  logic        rdz,
    input  int          drd,
    input  logic        erd,
    input  int          dwr,
    input  logic        ewr,
    output res_t        e
  );
    logic rw, dr, dw, ok;
    logic [31:0] opnd, old, nw;
    e = '{default: 0};
    rw   = (f3 == 3'b001) || (f3 == 3'b101);
    dr   = !(rw && rdz);
    dw   = rw || (fld != 5'd0);
    opnd = f3[2] ? {27'b0, fld} : v;
    old  = 32'h0;
    nw   = 32'h0;
    e.lat = 1;
    e.got = 1'b1;
    e.one = 1'b1;
    if (f3 == 3'b000 || f3 == 3'b100 || (a >= 12'hC00 && dw)) begin
      e.ill = 1'b1;
    end else begin
      ok = 1'b1;
      if (dr) begin
        e.n_rd    = 1;
        e.rd_addr = a;
        e.lat     = e.lat + acc_cycles(drd);
        if (drd >= TO || erd) begin
          e.ill = 1'b1;
          ok    = 1'b0;
        end else begin
          old     = mem_rd(a);
          e.rdata = old;
        end
      end
      if (ok && dw) begin
        if (rw)                nw = opnd;
        else if (f3[1:0] == 2) nw = old | opnd;
        else                   nw = old & ~opnd;
        e.n_wr    = 1;
        e.wr_addr = a;
        e.wr_data = nw;
        e.lat     = e.lat + acc_cycles(dwr);
        if (dwr >= TO || ewr) e.ill = 1'b1;
        else                  mem[a] = nw;
      end
    end
    e.inst = !e.ill;
  endtask

  // Issue one request and play the CSR file; collect observations
  task automatic run_req(
    input  logic [2:0]  f3,
    input  logic [11:0] a,
    input  logic [4:0]  fld,
    input  logic [31:0] v,
    input  logic        rdz,
    input  int          drd,
    input  logic        erd,
    input  int          dwr,
    input  logic        ewr,
    output res_t        o
  );
    logic prev_req, prev_done, ecur;
    int   acc, dcur;
    o = '{default: 0};
    prev_req  = 1'b0;
    prev_done = 1'b0;
    acc  = 0;
    dcur = 0;
    ecur = 1'b0;
    @(negedge clk);
    req_valid     = 1'b1;
    req_funct3    = f3;
    req_csr_addr  = a;
    req_rs1_field = fld;
    req_rs1_val   = v;
    req_rd_zero   = rdz;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      req_valid    = 1'b0;
      csr_done     = 1'b0;
      csr_error    = 1'b0;
      csr_data_out = '0;
      if (rsp_valid) begin
        o.got   = 1'b1;
        o.lat   = k;
        o.ill   = rsp_illegal;
        o.rdata = rsp_rdata;
        o.inst  = instret_inc;
        @(negedge clk);
        o.one = !rsp_valid && req_ready && !csr_req;
        break;
      end
      if (csr_req) begin
        if (!prev_req || prev_done) begin
          acc = 0;
          if (csr_operation) begin
            o.n_wr++;
            o.wr_addr = csr_addr;
            o.wr_data = csr_data_wr;
            dcur = dwr;
            ecur = ewr;
          end else begin
            o.n_rd++;
            o.rd_addr = csr_addr;
            dcur = drd;
            ecur = erd;
          end
        end
        acc++;
        if (acc == dcur + 1) begin
          csr_done     = 1'b1;
          csr_error    = ecur;
          csr_data_out = csr_operation ? $urandom : mem_rd(csr_addr);
        end
      end
      prev_req  = csr_req;
      prev_done = csr_done;
    end
    csr_done  = 1'b0;
    csr_error = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        csr_req !== 1'b0 || csr_operation !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: ready=%b rsp=%b req=%b op=%b, want 1 0 0 0",
               req_ready, rsp_valid, csr_req, csr_operation);
    end
    n_tests++;
    if (csr_addr !== 12'h0 || csr_data_wr !== 32'h0 || rsp_rdata !== 32'h0 ||
        rsp_illegal !== 1'b0 || instret_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wr=%h rd=%h ill=%b inst=%b, want zeros",
               csr_addr, csr_data_wr, rsp_rdata, rsp_illegal, instret_inc);
    end
  endtask

  task automatic test_rw;
    res_t o, e;
    mem[12'h341] = 32'h0;
    run_req(3'b001, 12'h341, 5'd3, 32'h45456767, 1'b0, 0, 0, 0, 0, o);
    model(3'b001, 12'h341, 5'd3, 32'h45456767, 1'b0, 0, 0, 0, 0, e);
    n_tests++;
    if (o.n_rd !== 1 || o.n_wr !== 1 || o.wr_data !== 32'h45456767) begin
      n_fail++;
      $display("FAIL rw_access: rd=%0d wr=%0d data=%h, want 1 1 45456767",
               o.n_rd, o.n_wr, o.wr_data);
    end
    n_tests++;
    if (o.rdata !== 32'h0 || o.ill !== 1'b0 || o.inst !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_rsp: rdata=%h ill=%b inst=%b, want 0 0 1",
               o.rdata, o.ill, o.inst);
    end
    n_tests++;
    if (o.lat !== e.lat || o.one !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_latency: lat=%0d one=%b, want %0d 1", o.lat, o.one, e.lat);
    end
  endtask

  task automatic test_set_clear;
    res_t o, e;
    mem[12'h342] = 32'h32324141;
    run_req(3'b010, 12'h342, 5'd7, 32'h4, 1'b0, 1, 0, 0, 0, o);
    model(3'b010, 12'h342, 5'd7, 32'h4, 1'b0, 1, 0, 0, 0, e);
    n_tests++;
    if (o.wr_data !== 32'h32324145 || o.rdata !== 32'h32324141) begin
      n_fail++;
      $display("FAIL csrrs: wr=%h rdata=%h, want 32324145 32324141",
               o.wr_data, o.rdata);
    end
    run_req(3'b111, 12'h342, 5'd1, 32'hFFFFFFFF, 1'b0, 0, 0, 2, 0, o);
    model(3'b111, 12'h342, 5'd1, 32'hFFFFFFFF, 1'b0, 0, 0, 2, 0, e);
    n_tests++;
    if (o.wr_data !== 32'h32324144 || o.rdata !== 32'h32324145) begin
      n_fail++;
      $display("FAIL csrrci: wr=%h rdata=%h, want 32324144 32324145",
               o.wr_data, o.rdata);
    end
    n_tests++;
    if (o.lat !== e.lat) begin
      n_fail++;
      $display("FAIL csrrci_lat: lat=%0d want %0d", o.lat, e.lat);
    end
  endtask

  task automatic test_single_access;
    res_t o, e;
    mem[12'hB00] = 32'h1234ABCD;
    run_req(3'b010, 12'hB00, 5'd0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0, o);
    model(3'b010, 12'hB00, 5'd0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0, e);
    n_tests++;
    if (o.n_rd !== 1 || o.n_wr !== 0 || o.rdata !== 32'h1234ABCD || o.lat !== 2) begin
      n_fail++;
      $display("FAIL read_only_op: rd=%0d wr=%0d rdata=%h lat=%0d, want 1 0 1234abcd 2",
               o.n_rd, o.n_wr, o.rdata, o.lat);
    end
    run_req(3'b001, 12'h305, 5'd9, 32'hCAFE0000, 1'b1, 0, 0, 0, 0, o);
    model(3'b001, 12'h305, 5'd9, 32'hCAFE0000, 1'b1, 0, 0, 0, 0, e);
    n_tests++;
    if (o.n_rd !== 0 || o.n_wr !== 1 || o.wr_data !== 32'hCAFE0000 ||
        o.rdata !== 32'h0 || o.lat !== 2) begin
      n_fail++;
      $display("FAIL write_only_op: rd=%0d wr=%0d data=%h rdata=%h lat=%0d, want 0 1 cafe0000 0 2",
               o.n_rd, o.n_wr, o.wr_data, o.rdata, o.lat);
    end
  endtask

  task automatic test_illegal;
    res_t o, e;
    run_req(3'b001, 12'hC01, 5'd4, 32'h1, 1'b0, 0, 0, 0, 0, o);
    model(3'b001, 12'hC01, 5'd4, 32'h1, 1'b0, 0, 0, 0, 0, e);
    n_tests++;
    if (o.ill !== 1'b1 || o.inst !== 1'b0 || o.n_rd + o.n_wr !== 0 || o.lat !== 1) begin
      n_fail++;
      $display("FAIL ro_write: ill=%b inst=%b acc=%0d lat=%0d, want 1 0 0 1",
               o.ill, o.inst, o.n_rd + o.n_wr, o.lat);
    end
    run_req(3'b100, 12'h341, 5'd4, 32'h1, 1'b0, 0, 0, 0, 0, o);
    model(3'b100, 12'h341, 5'd4, 32'h1, 1'b0, 0, 0, 0, 0, e);
    n_tests++;
    if (o.ill !== 1'b1 || o.n_rd + o.n_wr !== 0 || o.lat !== 1) begin
      n_fail++;
      $display("FAIL funct3_100: ill=%b acc=%0d lat=%0d, want 1 0 1",
               o.ill, o.n_rd + o.n_wr, o.lat);
    end
    mem[12'hC01] = 32'h00C0FFEE;
    run_req(3'b010, 12'hC01, 5'd0, 32'h5, 1'b0, 0, 0, 0, 0, o);
    model(3'b010, 12'hC01, 5'd0, 32'h5, 1'b0, 0, 0, 0, 0, e);
    n_tests++;
    if (o.ill !== 1'b0 || o.n_rd !== 1 || o.rdata !== 32'h00C0FFEE) begin
      n_fail++;
      $display("FAIL ro_read: ill=%b rd=%0d rdata=%h, want 0 1 00c0ffee",
               o.ill, o.n_rd, o.rdata);
    end
  endtask

  task automatic test_error_timeout;
    res_t o, e;
    run_req(3'b001, 12'h305, 5'd1, 32'h11, 1'b1, 0, 0, 0, 1, o);
    model(3'b001, 12'h305, 5'd1, 32'h11, 1'b1, 0, 0, 0, 1, e);
    n_tests++;
    if (o.ill !== 1'b1 || o.inst !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_error: ill=%b inst=%b, want 1 0", o.ill, o.inst);
    end
    run_req(3'b001, 12'h305, 5'd1, 32'h22, 1'b1, 0, 0, 200, 0, o);
    model(3'b001, 12'h305, 5'd1, 32'h22, 1'b1, 0, 0, 200, 0, e);
    n_tests++;
    if (o.ill !== 1'b1 || o.lat !== TO + 1 || o.one !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: ill=%b lat=%0d one=%b, want 1 %0d 1",
               o.ill, o.lat, o.one, TO + 1);
    end
    run_req(3'b001, 12'h305, 5'd1, 32'h33, 1'b1, 0, 0, TO - 1, 0, o);
    model(3'b001, 12'h305, 5'd1, 32'h33, 1'b1, 0, 0, TO - 1, 0, e);
    n_tests++;
    if (o.ill !== 1'b0 || o.lat !== TO + 1) begin
      n_fail++;
      $display("FAIL done_last_cycle: ill=%b lat=%0d, want 0 %0d",
               o.ill, o.lat, TO + 1);
    end
  endtask

  task automatic test_reset_mid;
    res_t o, e;
    logic seen;
    @(negedge clk);
    req_valid     = 1'b1;
    req_funct3    = 3'b001;
    req_csr_addr  = 12'h341;
    req_rs1_field = 5'd2;
    req_rs1_val   = 32'h0BADF00D;
    req_rd_zero   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    csr_done     = 1'b1;
    csr_data_out = mem_rd(12'h341);
    @(negedge clk);
    csr_done = 1'b0;
    n_tests++;
    if (csr_req !== 1'b1 || csr_operation !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_wr: req=%b op=%b, want 1 1", csr_req, csr_operation);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (csr_req !== 1'b0 || csr_operation !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: req=%b op=%b rsp=%b, want 0 0 0",
               csr_req, csr_operation, rsp_valid);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_rsp_after_reset: rsp_seen=%b want 0", seen);
    end
    run_req(3'b010, 12'h341, 5'd3, 32'h00F0, 1'b0, 1, 0, 0, 0, o);
    model(3'b010, 12'h341, 5'd3, 32'h00F0, 1'b0, 1, 0, 0, 0, e);
    n_tests++;
    if (o.got !== 1'b1 || o.rdata !== e.rdata || o.wr_data !== e.wr_data ||
        o.ill !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_req: got=%b rdata=%h wr=%h ill=%b, want 1 %h %h 0",
               o.got, o.rdata, o.wr_data, o.ill, e.rdata, e.wr_data);
    end
  endtask

  task automatic test_random;
    res_t o, e;
    logic [11:0] addrs [8];
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  fld;
    logic [31:0] v;
    logic        rdz, erd, ewr;
    int          drd, dwr, r;
    int          bad_acc, bad_data, bad_rsp, bad_lat;
    addrs = '{12'h305, 12'h341, 12'h342, 12'hB00,
              12'hC01, 12'hC81, 12'hB02, 12'h7C0};
    bad_acc  = 0;
    bad_data = 0;
    bad_rsp  = 0;
    bad_lat  = 0;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = addrs[$urandom_range(0, 7)];
      fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      v   = $urandom;
      rdz = 1'($urandom);
      r   = $urandom_range(0, 19);
      drd = (r < 15) ? r % 4 : ((r < 18) ? TO - 1 : TO + 3);
      r   = $urandom_range(0, 19);
      dwr = (r < 15) ? r % 4 : ((r < 18) ? TO - 1 : TO + 3);
      erd = ($urandom_range(0, 9) == 0);
      ewr = ($urandom_range(0, 9) == 0);
      run_req(f3, a, fld, v, rdz, drd, erd, dwr, ewr, o);
      model(f3, a, fld, v, rdz, drd, erd, dwr, ewr, e);
      n_tests++;
      if (o.n_rd !== e.n_rd || o.n_wr !== e.n_wr ||
          o.rd_addr !== e.rd_addr || o.wr_addr !== e.wr_addr) begin
        n_fail++;
        bad_acc++;
        $display("FAIL rnd_access[%0d]: rd=%0d wr=%0d ra=%h wa=%h, want %0d %0d %h %h",
                 i, o.n_rd, o.n_wr, o.rd_addr, o.wr_addr,
                 e.n_rd, e.n_wr, e.rd_addr, e.wr_addr);
      end
      n_tests++;
      if (o.wr_data !== e.wr_data || o.rdata !== e.rdata) begin
        n_fail++;
        bad_data++;
        $display("FAIL rnd_data[%0d]: f3=%b wr=%h rdata=%h, want %h %h",
                 i, f3, o.wr_data, o.rdata, e.wr_data, e.rdata);
      end
      n_tests++;
      if (o.got !== 1'b1 || o.ill !== e.ill || o.inst !== e.inst || o.one !== 1'b1) begin
        n_fail++;
        bad_rsp++;
        $display("FAIL rnd_rsp[%0d]: got=%b ill=%b inst=%b one=%b, want 1 %b %b 1",
                 i, o.got, o.ill, o.inst, o.one, e.ill, e.inst);
      end
      n_tests++;
      if (o.lat !== e.lat) begin
        n_fail++;
        bad_lat++;
        $display("FAIL rnd_latency[%0d]: lat=%0d want %0d", i, o.lat, e.lat);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_funct3    = 3'b000;
    req_csr_addr  = 12'h0;
    req_rs1_field = 5'd0;
    req_rs1_val   = '0;
    req_rd_zero   = 1'b0;
    csr_data_out  = '0;
    csr_done      = 1'b0;
    csr_error     = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_rw();
    test_set_clear();
    test_single_access();
    test_illegal();
    test_error_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
